// File: rtl/spi_master_multi_if.sv
// Request-side bus and shared SPI pins of spi_master_multi.
// Handshake: i_send is a level request sampled every cycle; it is taken only while
// the master is idle. Acceptance shows as o_busy high on the next cycle, rejection
// of an out-of-range i_sel as a one-cycle o_err. o_done marks o_data updated for one cycle.
interface spi_master_multi_if #(
  parameter int BITS     = 21,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
);
  logic [BITS-1:0]     i_data;
  logic                i_send;
  logic [SEL_W-1:0]    i_sel;
  logic [1:0]          i_mode;
  logic [BITS-1:0]     o_data;
  logic                o_busy;
  logic                o_done;
  logic                o_err;
  logic                i_miso;
  logic                o_mosi;
  logic                o_sclk;
  logic [N_SLAVES-1:0] o_ss;
  logic [2:0]          o_state;

  modport master (
    input  i_data, i_send, i_sel, i_mode, i_miso,
    output o_data, o_busy, o_done, o_err, o_mosi, o_sclk, o_ss, o_state
  );

  modport slave (
    output i_data, i_send, i_sel, i_mode, i_miso,
    input  o_data, o_busy, o_done, o_err, o_mosi, o_sclk, o_ss, o_state
  );
endinterface

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: per-transfer CPOL/CPHA, one-hot active-low selects,
// lead/trail/deselect phases of CLK_DIV cycles each, MSB-first words of BITS bits.
module spi_master_multi #(
  parameter int BITS     = 21,
  parameter int N_SLAVES = 4,
  parameter int CLK_DIV  = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  spi_master_multi_if.master bus
);
  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * BITS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(2 * BITS);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * BITS - 1);
  localparam logic [SEL_W:0]    SEL_LIM   = (SEL_W + 1)'(N_SLAVES);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [EDGE_W-1:0]   r_edge;
  logic [BITS-1:0]     r_tx;
  logic [BITS-1:0]     r_rx;
  logic [BITS-1:0]     r_data;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_mosi;
  logic                r_sclk;
  logic [N_SLAVES-1:0] r_ss;

  logic w_div_end;
  logic w_sel_ok;

  assign w_div_end = (r_div == DIV_LAST);
  assign w_sel_ok  = ({1'b0, bus.i_sel} < SEL_LIM);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_edge  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_data  <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_mosi  <= 1'b0;
      r_sclk  <= 1'b0;
      r_ss    <= '1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sclk <= bus.i_mode[1];
          r_div  <= '0;
          r_edge <= '0;
          if (bus.i_send) begin
            if (w_sel_ok) begin
              r_tx    <= bus.i_data;
              r_rx    <= '0;
              r_cpol  <= bus.i_mode[1];
              r_cpha  <= bus.i_mode[0];
              r_ss    <= ~(N_SLAVES'(1) << bus.i_sel);
              r_mosi  <= bus.i_mode[0] ? 1'b0 : bus.i_data[BITS-1];
              r_busy  <= 1'b1;
              r_state <= S_LEAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        // The end of LEAD is SCLK edge 0; each later CLK_DIV block ends in the next edge.
        S_LEAD, S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (r_edge == EDGE_END) begin
              r_state <= S_TRAIL;
            end else begin
              r_state <= S_SHIFT;
              r_edge  <= r_edge + 1'b1;
              r_sclk  <= ~r_sclk;
              // Even edges are leading: CPHA=0 samples there, CPHA=1 samples on odd ones.
              if (r_edge[0] == r_cpha) begin
                r_rx <= {r_rx[BITS-2:0], bus.i_miso};
              end else if (r_edge != EDGE_LAST) begin
                r_mosi <= r_cpha ? r_tx[BITS-1] : r_tx[BITS-2];
                r_tx   <= {r_tx[BITS-2:0], 1'b0};
              end
            end
          end
        end
        S_TRAIL: begin
          r_sclk <= r_cpol;
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div   <= '0;
            r_ss    <= '1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_data  <= r_rx;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_err   = r_err;
  assign bus.o_mosi  = r_mosi;
  assign bus.o_sclk  = r_sclk;
  assign bus.o_ss    = r_ss;
  assign bus.o_state = r_state;
endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: a 4-slave and a 3-slave instance,
// an SPI edge monitor / slave model, and a scoreboard of expected received words.
module tb_spi_master_multi;
  logic clk;
  logic rst;

  spi_master_multi_if #(.BITS(21), .N_SLAVES(4)) bus4 ();
  spi_master_multi_if #(.BITS(21), .N_SLAVES(3)) bus3 ();

  spi_master_multi #(.BITS(21), .N_SLAVES(4), .CLK_DIV(2)) dut4 (
    .i_clk(clk), .i_rst(rst), .bus(bus4.master)
  );
  spi_master_multi #(.BITS(21), .N_SLAVES(3), .CLK_DIV(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .bus(bus3.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [20:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor state
  logic [1:0]  cur_mode = 2'b00;
  int          miso_src = 0;
  logic [20:0] slv_word = '0;
  logic        slave_bit = 1'b0;
  logic [3:0]  exp_ss = 4'hF;
  logic        prev_sclk = 1'b0;
  logic [20:0] cap_mosi = '0;
  int busy_cnt = 0;
  int rise_cnt = 0;
  int ss_bad = 0;
  int ss_act = 0;
  int done_cnt = 0;
  int err3_cnt = 0;

  always_comb begin
    case (miso_src)
      1:       bus4.i_miso = 1'b1;
      2:       bus4.i_miso = slave_bit;
      default: bus4.i_miso = bus4.o_mosi;
    endcase
  end

  always @(negedge clk) begin
    logic lead;
    if (bus4.o_busy) busy_cnt++;
    if (bus4.o_ss != 4'hF) begin
      if (bus4.o_ss == exp_ss) ss_act++;
      else ss_bad++;
      if (bus4.o_sclk != prev_sclk) begin
        lead = (bus4.o_sclk != cur_mode[1]);
        if (bus4.o_sclk) rise_cnt++;
        if (lead != cur_mode[0]) begin
          cap_mosi = {cap_mosi[19:0], bus4.o_mosi};
        end else if (miso_src == 2) begin
          slave_bit = slv_word[20];
          slv_word  = {slv_word[19:0], 1'b0};
        end
      end
    end
    prev_sclk = bus4.o_sclk;
    if (bus3.o_err) err3_cnt++;
  end

  // scoreboard: compare each completion against the oldest expected word
  always @(negedge clk) begin
    if (!rst && bus4.o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
      else check_eq("rx_data", bus4.o_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic start_xfer(input logic [20:0] data, input logic [1:0] sel,
                            input logic [1:0] mode, input int msrc,
                            input logic [20:0] sw, input logic [20:0] exp_rx);
    @(negedge clk);
    bus4.i_mode = mode;
    bus4.i_sel  = sel;
    bus4.i_data = data;
    @(negedge clk);
    cur_mode = mode;
    miso_src = msrc;
    slv_word = sw;
    exp_ss   = ~(4'b0001 << sel);
    busy_cnt = 0;
    rise_cnt = 0;
    ss_bad   = 0;
    ss_act   = 0;
    cap_mosi = '0;
    bus4.i_send = 1'b1;
    exp_q.push_back(exp_rx);
    @(negedge clk);
    bus4.i_send = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_xfer(input string tag, input logic [20:0] tx);
    check_eq({tag, "_busy_cycles"}, busy_cnt, 32'd90);
    check_eq({tag, "_sclk_rises"}, rise_cnt, 32'd21);
    check_eq({tag, "_ss_other"}, ss_bad, 32'd0);
    check_eq({tag, "_ss_cycles"}, ss_act, 32'd88);
    check_eq({tag, "_mosi_word"}, cap_mosi, tx);
  endtask

  initial begin
    int base;
    int sclk_moves;
    rst = 1'b1;
    bus4.i_data = '0; bus4.i_send = 1'b0; bus4.i_sel = '0; bus4.i_mode = 2'b00;
    bus3.i_data = '0; bus3.i_send = 1'b0; bus3.i_sel = '0; bus3.i_mode = 2'b00;
    bus3.i_miso = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", bus4.o_data, 32'h0);
    check_eq("rst_busy", bus4.o_busy, 32'h0);
    check_eq("rst_done", bus4.o_done, 32'h0);
    check_eq("rst_err", bus4.o_err, 32'h0);
    check_eq("rst_mosi", bus4.o_mosi, 32'h0);
    check_eq("rst_sclk", bus4.o_sclk, 32'h0);
    check_eq("rst_ss", bus4.o_ss, 32'hF);
    check_eq("rst_state", bus4.o_state, 32'h0);
    check_eq("rst_ss3", bus3.o_ss, 32'h7);
    rst = 1'b0;

    // mode 0, slave 0, loopback
    start_xfer(21'h1A5A5A, 2'd0, 2'b00, 0, '0, 21'h1A5A5A);
    wait_done(1);
    check_xfer("m0", 21'h1A5A5A);

    // mode 3, slave 2, MISO tied high; SCLK idles high first
    @(negedge clk);
    bus4.i_mode = 2'b11;
    @(negedge clk);
    check_eq("idle_cpol1", bus4.o_sclk, 32'h1);
    start_xfer(21'h012345, 2'd2, 2'b11, 1, '0, 21'h1FFFFF);
    wait_done(2);
    check_xfer("m3", 21'h012345);

    // mode 1, slave 1, slave model drives 0ABCDE on leading edges
    start_xfer(21'h15A3C7, 2'd1, 2'b01, 2, 21'h0ABCDE, 21'h0ABCDE);
    wait_done(3);
    check_xfer("m1", 21'h15A3C7);

    // 3-slave instance: out-of-range select is rejected
    @(negedge clk);
    err3_cnt = 0;
    bus3.i_sel = 2'd3;
    bus3.i_data = 21'h1FFFFF;
    bus3.i_send = 1'b1;
    @(negedge clk);
    bus3.i_send = 1'b0;
    check_eq("err_pulse", bus3.o_err, 32'h1);
    check_eq("err_busy", bus3.o_busy, 32'h0);
    check_eq("err_ss", bus3.o_ss, 32'h7);
    sclk_moves = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus3.o_sclk !== 1'b0 || bus3.o_busy !== 1'b0 || bus3.o_ss !== 3'b111) sclk_moves++;
    end
    check_eq("err_count", err3_cnt, 32'd1);
    check_eq("err_quiet", sclk_moves, 32'd0);

    // request while busy is ignored
    start_xfer(21'h000001, 2'd0, 2'b00, 0, '0, 21'h000001);
    repeat (10) @(negedge clk);
    bus4.i_send = 1'b1; bus4.i_data = 21'h1FFFFF; bus4.i_sel = 2'd3; bus4.i_mode = 2'b11;
    repeat (20) @(negedge clk);
    bus4.i_send = 1'b0; bus4.i_mode = 2'b00;
    wait_done(4);
    check_xfer("busy_ign", 21'h000001);
    @(negedge clk);
    check_eq("busy_ign_idle", bus4.o_busy, 32'h0);

    // back-to-back: i_send held through the done cycle
    @(negedge clk);
    bus4.i_data = 21'h155555; bus4.i_sel = 2'd0; bus4.i_mode = 2'b00;
    cur_mode = 2'b00; miso_src = 0; exp_ss = 4'hE;
    @(negedge clk);
    exp_q.push_back(21'h155555);
    exp_q.push_back(21'h155555);
    bus4.i_send = 1'b1;
    base = 0;
    @(negedge clk);
    while (!bus4.o_done && base < 300) begin
      @(negedge clk);
      base++;
    end
    check_eq("b2b_first_done", bus4.o_done, 32'h1);
    @(negedge clk);
    bus4.i_send = 1'b0;
    check_eq("b2b_accept", bus4.o_busy, 32'h1);
    wait_done(6);

    // reset in the middle of a transfer
    start_xfer(21'h1A5A5A, 2'd3, 2'b00, 0, '0, 21'h1A5A5A);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    base = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", bus4.o_busy, 32'h0);
    check_eq("mid_rst_ss", bus4.o_ss, 32'hF);
    check_eq("mid_rst_sclk", bus4.o_sclk, 32'h0);
    check_eq("mid_rst_data", bus4.o_data, 32'h0);
    check_eq("mid_rst_done", bus4.o_done, 32'h0);
    repeat (100) @(negedge clk);
    check_eq("mid_rst_no_done", done_cnt, base);
    check_eq("mid_rst_state", bus4.o_state, 32'h0);
    start_xfer(21'h0F0F0F, 2'd3, 2'b00, 0, '0, 21'h0F0F0F);
    wait_done(base + 1);
    check_xfer("post_rst", 21'h0F0F0F);

    repeat (4) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
